// File: rtl/misc_edge_detector_multi.sv
// -----------------------------------------------------------------------------
// misc_edge_detector_multi
//
// Multi-channel synchronising, glitch-filtering edge detector. Each raw
// asynchronous input passes through a SYNC_STAGES flop synchroniser and then
// a debounce filter that accepts a level change only after the synchronised
// value has differed from the current level for FILTER_CYCLES consecutive
// cycles (FILTER_CYCLES = 0 bypasses the filter). Accepted changes produce
// registered one-cycle rising/falling pulses, a mode-qualified event pulse,
// a sticky pending flag per channel and a combined interrupt.
//
// Ports:
//   clk             system clock, all state on rising edge
//   rst             asynchronous active-high reset
//   i_signal        [CHANNELS]   raw asynchronous inputs
//   i_edge_mode     [2*CHANNELS] per channel {falling_en, rising_en}
//   i_irq_en        [CHANNELS]   per-channel interrupt enable
//   i_pending_clr   [CHANNELS]   per-channel clear of the pending flag
//   o_level         [CHANNELS]   filtered, synchronised level
//   o_rising_edge   [CHANNELS]   1-cycle pulse on an accepted 0->1 change
//   o_falling_edge  [CHANNELS]   1-cycle pulse on an accepted 1->0 change
//   o_event         [CHANNELS]   edge pulse qualified by i_edge_mode
//   o_pending       [CHANNELS]   sticky event flags
//   o_irq                        OR of (pending & irq_en)
// -----------------------------------------------------------------------------
module misc_edge_detector_multi #(
  parameter int CHANNELS      = 8,
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 4,
  parameter bit INIT_LEVEL    = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [CHANNELS-1:0]     i_signal,
  input  logic [2*CHANNELS-1:0]   i_edge_mode,
  input  logic [CHANNELS-1:0]     i_irq_en,
  input  logic [CHANNELS-1:0]     i_pending_clr,
  output logic [CHANNELS-1:0]     o_level,
  output logic [CHANNELS-1:0]     o_rising_edge,
  output logic [CHANNELS-1:0]     o_falling_edge,
  output logic [CHANNELS-1:0]     o_event,
  output logic [CHANNELS-1:0]     o_pending,
  output logic                    o_irq
);

  localparam logic [CHANNELS-1:0] INIT_VEC = {CHANNELS{INIT_LEVEL}};

  logic [CHANNELS-1:0] r_sync [SYNC_STAGES];
  logic [CHANNELS-1:0] w_sync_out;
  logic [CHANNELS-1:0] w_level_next;
  logic [CHANNELS-1:0] r_level;
  logic [CHANNELS-1:0] r_level_d;
  logic [CHANNELS-1:0] r_rise;
  logic [CHANNELS-1:0] r_fall;
  logic [CHANNELS-1:0] r_pending;
  logic [CHANNELS-1:0] w_event;

  // Synchroniser: plain shift chain, nothing between the stages.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < SYNC_STAGES; s++) r_sync[s] <= INIT_VEC;
    end else begin
      r_sync[0] <= i_signal;
      for (int s = 1; s < SYNC_STAGES; s++) r_sync[s] <= r_sync[s-1];
    end
  end

  assign w_sync_out = r_sync[SYNC_STAGES-1];

  generate
    if (FILTER_CYCLES == 0) begin : g_bypass
      assign w_level_next = w_sync_out;
    end else begin : g_filter
      localparam int            CW   = $clog2(FILTER_CYCLES + 1);
      localparam logic [CW-1:0] CMAX = CW'(FILTER_CYCLES - 1);

      logic [CW-1:0] r_cnt [CHANNELS];

      // A mismatch must persist for FILTER_CYCLES consecutive cycles; the
      // counter restarts as soon as the synchronised value agrees again.
      always_comb begin
        w_level_next = r_level;
        for (int c = 0; c < CHANNELS; c++) begin
          if ((w_sync_out[c] != r_level[c]) && (r_cnt[c] == CMAX))
            w_level_next[c] = w_sync_out[c];
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int c = 0; c < CHANNELS; c++) r_cnt[c] <= '0;
        end else begin
          for (int c = 0; c < CHANNELS; c++) begin
            if ((w_sync_out[c] == r_level[c]) || (r_cnt[c] == CMAX))
              r_cnt[c] <= '0;
            else
              r_cnt[c] <= r_cnt[c] + 1'b1;
          end
        end
      end
    end
  endgenerate

  // Level, its one-cycle delayed copy and the edge pulses. The pulses are
  // derived from the registered level, so they appear the cycle after the
  // level changes; reset loads both copies with INIT_LEVEL so release alone
  // can never create a pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_level   <= INIT_VEC;
      r_level_d <= INIT_VEC;
      r_rise    <= '0;
      r_fall    <= '0;
    end else begin
      r_level   <= w_level_next;
      r_level_d <= r_level;
      r_rise    <= r_level & ~r_level_d;
      r_fall    <= ~r_level & r_level_d;
    end
  end

  // Mode qualification is combinational on the registered pulses, so a
  // mode change alone can never raise an event.
  always_comb begin
    w_event = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      w_event[i] = (r_rise[i] & i_edge_mode[2*i]) |
                   (r_fall[i] & i_edge_mode[2*i+1]);
    end
  end

  // Set has priority over clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_pending <= '0;
    else     r_pending <= (r_pending & ~i_pending_clr) | w_event;
  end

  assign o_level        = r_level;
  assign o_rising_edge  = r_rise;
  assign o_falling_edge = r_fall;
  assign o_event        = w_event;
  assign o_pending      = r_pending;
  assign o_irq          = |(r_pending & i_irq_en);

endmodule

// File: tb/tb_misc_edge_detector_multi.sv
module tb_misc_edge_detector_multi;

  logic clk;
  logic rst = 1'b1;

  // Default-parameter instance
  logic [7:0]  sig, irq_en, clr;
  logic [15:0] mode;
  logic [7:0]  o_level, o_rise, o_fall, o_event, o_pend;
  logic        o_irq;

  // FILTER_CYCLES=0, SYNC_STAGES=3, INIT_LEVEL=1 instance
  logic [7:0]  d2_sig;
  logic [7:0]  d2_level, d2_rise, d2_fall, d2_event, d2_pend;
  logic        d2_irq;

  int total = 0;
  int bad   = 0;

  misc_edge_detector_multi #(
    .CHANNELS(8), .SYNC_STAGES(2), .FILTER_CYCLES(4), .INIT_LEVEL(1'b0)
  ) dut (
    .clk(clk), .rst(rst), .i_signal(sig), .i_edge_mode(mode),
    .i_irq_en(irq_en), .i_pending_clr(clr), .o_level(o_level),
    .o_rising_edge(o_rise), .o_falling_edge(o_fall), .o_event(o_event),
    .o_pending(o_pend), .o_irq(o_irq)
  );

  misc_edge_detector_multi #(
    .CHANNELS(8), .SYNC_STAGES(3), .FILTER_CYCLES(0), .INIT_LEVEL(1'b1)
  ) dut2 (
    .clk(clk), .rst(rst), .i_signal(d2_sig), .i_edge_mode(16'hFFFF),
    .i_irq_en(8'hFF), .i_pending_clr(8'h00), .o_level(d2_level),
    .o_rising_edge(d2_rise), .o_falling_edge(d2_fall), .o_event(d2_event),
    .o_pending(d2_pend), .o_irq(d2_irq)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model (default instance) -------
  // The synchronised value seen at any edge is simply the input sampled two
  // edges earlier; a level change is accepted once that value has disagreed
  // with the current level for 4 edges in a row.
  logic [7:0] m_hist[$];
  int         m_run[8];
  logic [7:0] m_level, m_level_d, m_rise, m_fall, m_pend;

  function automatic logic [7:0] rise_mask(input logic [15:0] m);
    logic [7:0] r;
    for (int c = 0; c < 8; c++) r[c] = m[2*c];
    return r;
  endfunction

  function automatic logic [7:0] fall_mask(input logic [15:0] m);
    logic [7:0] r;
    for (int c = 0; c < 8; c++) r[c] = m[2*c+1];
    return r;
  endfunction

  task automatic model_reset();
    m_hist = {};
    m_hist.push_back(8'h00);
    m_hist.push_back(8'h00);
    for (int c = 0; c < 8; c++) m_run[c] = 0;
    m_level = 0; m_level_d = 0; m_rise = 0; m_fall = 0; m_pend = 0;
  endtask

  task automatic model_edge();
    logic [7:0] so, ev;
    so = m_hist[0];
    ev = (m_rise & rise_mask(mode)) | (m_fall & fall_mask(mode));
    m_pend    = (m_pend & ~clr) | ev;
    m_rise    = m_level & ~m_level_d;
    m_fall    = ~m_level & m_level_d;
    m_level_d = m_level;
    for (int c = 0; c < 8; c++) begin
      if (so[c] != m_level[c]) begin
        m_run[c]++;
        if (m_run[c] == 4) begin
          m_level[c] = so[c];
          m_run[c]   = 0;
        end
      end else begin
        m_run[c] = 0;
      end
    end
    m_hist.push_back(sig);
    void'(m_hist.pop_front());
  endtask

  task automatic model_check();
    chk("m_level",   32'(o_level), 32'(m_level));
    chk("m_rise",    32'(o_rise),  32'(m_rise));
    chk("m_fall",    32'(o_fall),  32'(m_fall));
    chk("m_event",   32'(o_event), 32'((m_rise & rise_mask(mode)) | (m_fall & fall_mask(mode))));
    chk("m_pending", 32'(o_pend),  32'(m_pend));
    chk("m_irq",     32'(o_irq),   32'(|(m_pend & irq_en)));
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) model_reset();
    else     model_edge();
    #1;
    model_check();
  endtask

  typedef struct {
    logic [7:0] clr;
    logic [7:0] en;
    logic [7:0] exp_pend;
    logic       exp_irq;
  } vec_t;

  vec_t vt[6];

  initial begin
    int n;
    int c_rise, c_fall, c_ev, c_evf;

    vt[0] = '{8'h00, 8'hFF, 8'hFF, 1'b1};
    vt[1] = '{8'h0F, 8'hF0, 8'hF0, 1'b1};
    vt[2] = '{8'h00, 8'h0F, 8'hF0, 1'b0};
    vt[3] = '{8'h30, 8'h80, 8'hC0, 1'b1};
    vt[4] = '{8'hC0, 8'h3F, 8'h00, 1'b0};
    vt[5] = '{8'hFF, 8'hFF, 8'h00, 1'b0};

    sig = 0; irq_en = 0; clr = 0; mode = 0; d2_sig = 0;
    model_reset();

    // ---- reset state
    rst = 1'b1;
    tick(); tick();
    chk("rst_level",   32'(o_level), 0);
    chk("rst_pending", 32'(o_pend), 0);
    chk("rst_irq",     32'(o_irq), 0);
    chk("rst_d2_level", 32'(d2_level), 32'hFF);
    chk("rst_d2_pulse", 32'(d2_rise | d2_fall), 0);
    rst = 1'b0;

    // ---- FILTER_CYCLES=0 instance: release with input != INIT_LEVEL
    for (int k = 1; k <= 6; k++) begin
      tick();
      chk("d2_rel_level", 32'(d2_level), (k >= 4) ? 32'h00 : 32'hFF);
      chk("d2_rel_rise",  32'(d2_rise), 0);
      chk("d2_rel_fall",  32'(d2_fall), (k == 5) ? 32'hFF : 32'h00);
    end
    d2_sig[0] = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      if (k == 2) d2_sig[0] = 1'b0;
      tick();
      chk("d2_pulse_level", 32'(d2_level[0]), 32'(k == 4));
      chk("d2_pulse_rise",  32'(d2_rise[0]),  32'(k == 5));
      chk("d2_pulse_fall",  32'(d2_fall[0]),  32'(k == 6));
    end

    // ---- latency on ch0, mode 01
    mode = 16'h0001; irq_en = 8'h01; sig[0] = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      chk("lat_level0", 32'(o_level[0]), 32'(k >= 6));
      chk("lat_rise0",  32'(o_rise[0]),  32'(k == 7));
      chk("lat_event0", 32'(o_event[0]), 32'(k == 7));
      chk("lat_pend0",  32'(o_pend[0]),  32'(k >= 8));
      chk("lat_irq",    32'(o_irq),      32'(k >= 8));
    end
    irq_en = 8'h00;
    tick();
    chk("irqen_gate_irq",  32'(o_irq), 0);
    chk("irqen_gate_pend", 32'(o_pend[0]), 1);
    clr = 8'h01; tick(); clr = 8'h00;
    chk("clr_pend0", 32'(o_pend[0]), 0);

    // ---- glitch rejection on ch3
    mode[7:6] = 2'b11;
    sig[3] = 1'b1; repeat (3) tick(); sig[3] = 1'b0;
    n = 0;
    for (int k = 0; k < 15; k++) begin
      tick();
      n += int'(o_level[3]) + int'(o_rise[3]) + int'(o_pend[3]);
    end
    chk("glitch3_reject", n, 0);
    sig[3] = 1'b1; repeat (4) tick(); sig[3] = 1'b0;
    c_rise = 0; c_fall = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      c_rise += int'(o_rise[3]);
      c_fall += int'(o_fall[3]);
    end
    chk("glitch3_accept_rise", c_rise, 1);
    chk("glitch3_accept_fall", c_fall, 1);
    chk("glitch3_accept_pend", 32'(o_pend[3]), 1);

    // ---- mode masking: ch1 falling only, ch4 none
    clr = 8'hFF; tick(); clr = 8'h00;
    mode[3:2] = 2'b10; mode[9:8] = 2'b00;
    c_rise = 0; c_fall = 0; c_ev = 0; c_evf = 0; n = 0;
    sig[1] = 1'b1; sig[4] = 1'b1;
    for (int k = 0; k < 25; k++) begin
      if (k == 10) begin sig[1] = 1'b0; sig[4] = 1'b0; end
      tick();
      c_rise += int'(o_rise[1]);
      c_fall += int'(o_fall[1]);
      c_ev   += int'(o_event[1]);
      c_evf  += int'(o_event[1] & o_fall[1]);
      n      += int'(o_event[4]);
    end
    chk("mask1_rise",   c_rise, 1);
    chk("mask1_fall",   c_fall, 1);
    chk("mask1_event",  c_ev, 1);
    chk("mask1_evfall", c_evf, 1);
    chk("mask1_pend",   32'(o_pend[1]), 1);
    chk("mask4_event",  n, 0);
    chk("mask4_pend",   32'(o_pend[4]), 0);

    // ---- set/clear collision on ch2
    mode[5:4] = 2'b11; clr = 8'h04; sig[2] = 1'b1;
    n = 0;
    do begin tick(); n++; end while (!o_event[2] && n < 20);
    chk("coll_event_seen", 32'(o_event[2]), 1);
    tick();
    chk("coll_set_wins", 32'(o_pend[2]), 1);
    clr = 8'h00; tick();
    chk("coll_hold", 32'(o_pend[2]), 1);
    clr = 8'h04; tick();
    chk("coll_clear", 32'(o_pend[2]), 0);
    clr = 8'h00;

    // ---- all channels at once
    mode = 16'hFFFF; irq_en = 8'hFF;
    clr = 8'hFF; tick(); clr = 8'h00;
    sig = ~sig;
    n = 0;
    do begin tick(); n++; end while (o_event == 8'h00 && n < 20);
    chk("all_event", 32'(o_event), 32'hFF);
    tick();
    chk("all_pend", 32'(o_pend), 32'hFF);
    chk("all_irq",  32'(o_irq), 1);

    // ---- table: clear / irq_en combinations on a full pending set
    for (int i = 0; i < 6; i++) begin
      clr = vt[i].clr; irq_en = vt[i].en;
      tick();
      chk("tbl_pend", 32'(o_pend), 32'(vt[i].exp_pend));
      chk("tbl_irq",  32'(o_irq),  32'(vt[i].exp_irq));
    end
    clr = 8'h00;

    // ---- randomized run against the model, with a mid-run reset
    for (int k = 0; k < 3000; k++) begin
      if (k == 1500) begin
        #2; rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
      end
      for (int c = 0; c < 8; c++)
        if ($urandom_range(0, 5) == 0) sig[c] = ~sig[c];
      if ($urandom_range(0, 49) == 0) mode = 16'($urandom);
      irq_en = 8'($urandom);
      clr = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'h00;
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
